// File: rtl/alu_control_seq.sv
// Registered ALU control decoder with valid/ready handshake and stall.
// Define ALU_CTRL_MEXT_EN to enable multi-cycle M-extension sequencing.
module alu_control_seq #(
    parameter int OP_W       = 5,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [6:0]      funct7_i,
    input  logic [2:0]      ALU_Op_i,
    input  logic [2:0]      funct3_i,
    output logic            valid_o,
    output logic [OP_W-1:0] ALU_Operation_o,
    output logic            stall_o,
    output logic            illegal_o
);

    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;
    localparam logic [4:0] OP_OR  = 5'b00010;
    localparam logic [4:0] OP_SLL = 5'b00011;
    localparam logic [4:0] OP_SRL = 5'b00100;
    localparam logic [4:0] OP_LUI = 5'b00101;
    localparam logic [4:0] OP_AND = 5'b00110;
    localparam logic [4:0] OP_XOR = 5'b00111;
    localparam logic [4:0] OP_BEQ = 5'b01000;
    localparam logic [4:0] OP_BNE = 5'b01001;
    localparam logic [4:0] OP_BLT = 5'b01010;
    localparam logic [4:0] OP_BGE = 5'b01011;
    localparam logic [4:0] OP_JAL = 5'b01100;
    localparam logic [4:0] OP_SW  = 5'b01101;
    localparam logic [4:0] OP_SRA = 5'b01110;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    typedef enum logic {
        IDLE,
        MULTI
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [OP_W-1:0] op_q, op_d;
    logic            ill_q, ill_d;
    logic            valid_q, valid_d;

    logic [4:0]      dec_op;
    logic            dec_ill;
    logic            dec_multi;
    logic [CW-1:0]   dec_lat;

    // Translate {funct7, ALU_Op, funct3} into an operation code.
    always_comb begin
        dec_op    = OP_ADD;
        dec_ill   = 1'b1;
        dec_multi = 1'b0;
        dec_lat   = '0;
        unique case (ALU_Op_i)
            3'b000: begin
                unique case (funct7_i)
                    F7_BASE: begin
                        dec_ill = 1'b0;
                        unique case (funct3_i)
                            3'b000: dec_op = OP_ADD;
                            3'b001: dec_op = OP_SLL;
                            3'b100: dec_op = OP_XOR;
                            3'b101: dec_op = OP_SRL;
                            3'b110: dec_op = OP_OR;
                            3'b111: dec_op = OP_AND;
                            default: dec_ill = 1'b1;
                        endcase
                    end
                    F7_ALT: begin
                        dec_ill = 1'b0;
                        unique case (funct3_i)
                            3'b000: dec_op = OP_SUB;
                            3'b101: dec_op = OP_SRA;
                            default: dec_ill = 1'b1;
                        endcase
                    end
                    F7_MEXT: begin
`ifdef ALU_CTRL_MEXT_EN
                        dec_ill = 1'b0;
                        dec_op  = {2'b10, funct3_i};
                        if (funct3_i[2]) begin
                            dec_multi = (DIV_CYCLES > 1);
                            dec_lat   = CW'(DIV_CYCLES - 1);
                        end else begin
                            dec_multi = (MUL_CYCLES > 1);
                            dec_lat   = CW'(MUL_CYCLES - 1);
                        end
`else
                        dec_ill = 1'b1;
`endif
                    end
                    default: dec_ill = 1'b1;
                endcase
            end
            3'b001: begin
                dec_ill = 1'b0;
                unique case (funct3_i)
                    3'b000: dec_op = OP_ADD;
                    3'b010: dec_op = OP_ADD;
                    3'b100: dec_op = OP_XOR;
                    3'b110: dec_op = OP_OR;
                    3'b111: dec_op = OP_AND;
                    3'b001: begin
                        dec_op  = OP_SLL;
                        dec_ill = (funct7_i != F7_BASE);
                    end
                    3'b101: begin
                        if (funct7_i == F7_BASE)
                            dec_op = OP_SRL;
                        else if (funct7_i == F7_ALT)
                            dec_op = OP_SRA;
                        else
                            dec_ill = 1'b1;
                    end
                    default: dec_ill = 1'b1;
                endcase
            end
            3'b010: begin
                dec_ill = 1'b0;
                dec_op  = OP_LUI;
            end
            3'b011: begin
                dec_ill = (funct3_i != 3'b010);
                dec_op  = OP_SW;
            end
            3'b100: begin
                dec_ill = 1'b0;
                unique case (funct3_i)
                    3'b000: dec_op = OP_BEQ;
                    3'b001: dec_op = OP_BNE;
                    3'b100: dec_op = OP_BLT;
                    3'b101: dec_op = OP_BGE;
                    default: dec_ill = 1'b1;
                endcase
            end
            3'b101: begin
                dec_ill = 1'b0;
                dec_op  = OP_JAL;
            end
            default: dec_ill = 1'b1;
        endcase
        // An illegal request always reports code 0 and never stalls.
        if (dec_ill) begin
            dec_op    = OP_ADD;
            dec_multi = 1'b0;
            dec_lat   = '0;
        end
    end

    assign ready_o = (state_q == IDLE) & ~reset;

    // Next-state and output-register logic for the accept/stall sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        ill_d   = ill_q;
        valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (valid_i && ready_o) begin
                    op_d  = OP_W'(dec_op);
                    ill_d = dec_ill;
                    if (dec_multi) begin
                        state_d = MULTI;
                        cnt_d   = dec_lat;
                    end else begin
                        valid_d = 1'b1;
                    end
                end
            end
            MULTI: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counter and registered outputs; reset aborts any operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            ill_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            ill_q   <= ill_d;
            valid_q <= valid_d;
        end
    end

`ifdef ALU_CTRL_MEXT_EN
    assign stall_o = (state_q == MULTI);
`else
    assign stall_o = 1'b0;
`endif

    assign valid_o         = valid_q;
    assign ALU_Operation_o = op_q;
    assign illegal_o       = ill_q;

endmodule

// File: tb/tb_alu_control_seq.sv
// Directed self-checking bench for alu_control_seq.
// Extra M-extension steps run when ALU_CTRL_MEXT_EN is defined.
module tb_alu_control_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid_i;
    logic       ready_o;
    logic [6:0] funct7_i;
    logic [2:0] ALU_Op_i;
    logic [2:0] funct3_i;
    logic       valid_o;
    logic [4:0] ALU_Operation_o;
    logic       stall_o;
    logic       illegal_o;

    int tests = 0;
    int fails = 0;

    alu_control_seq #(
        .OP_W(5),
        .MUL_CYCLES(4),
        .DIV_CYCLES(32)
    ) dut (
        .clk(clk),
        .reset(reset),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .funct7_i(funct7_i),
        .ALU_Op_i(ALU_Op_i),
        .funct3_i(funct3_i),
        .valid_o(valid_o),
        .ALU_Operation_o(ALU_Operation_o),
        .stall_o(stall_o),
        .illegal_o(illegal_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v,
                           input logic [4:0] op, input logic ill,
                           input logic st);
        chk({tag, ".valid"}, {31'd0, valid_o}, {31'd0, v});
        chk({tag, ".op"}, {27'd0, ALU_Operation_o}, {27'd0, op});
        chk({tag, ".ill"}, {31'd0, illegal_o}, {31'd0, ill});
        chk({tag, ".stall"}, {31'd0, stall_o}, {31'd0, st});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [6:0] f7, input logic [2:0] aop,
                       input logic [2:0] f3);
        valid_i  = 1'b1;
        funct7_i = f7;
        ALU_Op_i = aop;
        funct3_i = f3;
    endtask

    initial begin
        reset    = 1'b1;
        valid_i  = 1'b0;
        funct7_i = 7'd0;
        ALU_Op_i = 3'd0;
        funct3_i = 3'd0;

        step();
        step();
        chk_out("rst", 1'b0, 5'h00, 1'b0, 1'b0);
        chk("rst.ready", {31'd0, ready_o}, 32'd0);
        reset = 1'b0;
        #1;
        chk("post_rst.ready", {31'd0, ready_o}, 32'd1);

        req(7'b0100000, 3'b000, 3'b000);
        step();
        valid_i = 1'b0;
        chk_out("sub", 1'b1, 5'h01, 1'b0, 1'b0);
        step();
        chk_out("sub_hold", 1'b0, 5'h01, 1'b0, 1'b0);

        req(7'b0000000, 3'b001, 3'b000);
        step();
        chk_out("b2b_addi", 1'b1, 5'h00, 1'b0, 1'b0);
        req(7'b0100000, 3'b001, 3'b101);
        step();
        chk_out("b2b_srai", 1'b1, 5'h0E, 1'b0, 1'b0);
        req(7'b0000000, 3'b100, 3'b101);
        step();
        chk_out("b2b_bge", 1'b1, 5'h0B, 1'b0, 1'b0);
        req(7'b1111111, 3'b101, 3'b011);
        step();
        valid_i = 1'b0;
        chk_out("b2b_jal", 1'b1, 5'h0C, 1'b0, 1'b0);
        step();
        chk_out("jal_hold", 1'b0, 5'h0C, 1'b0, 1'b0);

        req(7'b0000000, 3'b100, 3'b010);
        step();
        valid_i = 1'b0;
        chk_out("br_ill", 1'b1, 5'h00, 1'b1, 1'b0);
        step();
        chk_out("br_ill_hold", 1'b0, 5'h00, 1'b1, 1'b0);

        req(7'b0000000, 3'b011, 3'b010);
        step();
        chk_out("sw", 1'b1, 5'h0D, 1'b0, 1'b0);
        req(7'b1010101, 3'b010, 3'b111);
        step();
        chk_out("lui", 1'b1, 5'h05, 1'b0, 1'b0);
        req(7'b0000000, 3'b000, 3'b101);
        step();
        chk_out("srl", 1'b1, 5'h04, 1'b0, 1'b0);
        req(7'b0000000, 3'b000, 3'b110);
        step();
        chk_out("or", 1'b1, 5'h02, 1'b0, 1'b0);
        req(7'b0100000, 3'b001, 3'b001);
        step();
        chk_out("slli_badf7", 1'b1, 5'h00, 1'b1, 1'b0);
        req(7'b0000000, 3'b001, 3'b111);
        step();
        chk_out("andi", 1'b1, 5'h06, 1'b0, 1'b0);
        req(7'b0000000, 3'b110, 3'b000);
        step();
        chk_out("aop110", 1'b1, 5'h00, 1'b1, 1'b0);
        req(7'b0100000, 3'b000, 3'b001);
        step();
        chk_out("r_badf7", 1'b1, 5'h00, 1'b1, 1'b0);
        req(7'b0000000, 3'b100, 3'b001);
        step();
        valid_i = 1'b0;
        chk_out("bne", 1'b1, 5'h09, 1'b0, 1'b0);
        step();

`ifdef ALU_CTRL_MEXT_EN
        req(7'b0000001, 3'b000, 3'b100);
        step();
        chk_out("div_acc", 1'b0, 5'h14, 1'b0, 1'b1);
        chk("div_acc.ready", {31'd0, ready_o}, 32'd0);
        req(7'b0000000, 3'b000, 3'b000);
        for (int i = 1; i < 32; i++) begin
            step();
            chk_out("div_busy", 1'b0, 5'h14, 1'b0, 1'b1);
            chk("div_busy.ready", {31'd0, ready_o}, 32'd0);
        end
        step();
        chk_out("div_done", 1'b1, 5'h14, 1'b0, 1'b0);
        chk("div_done.ready", {31'd0, ready_o}, 32'd1);
        step();
        valid_i = 1'b0;
        chk_out("after_div_add", 1'b1, 5'h00, 1'b0, 1'b0);
        step();

        req(7'b0000001, 3'b000, 3'b000);
        step();
        valid_i = 1'b0;
        chk_out("mul_acc", 1'b0, 5'h10, 1'b0, 1'b1);
        step();
        chk_out("mul_busy", 1'b0, 5'h10, 1'b0, 1'b1);
        reset = 1'b1;
        step();
        chk_out("mul_rst", 1'b0, 5'h00, 1'b0, 1'b0);
        chk("mul_rst.ready", {31'd0, ready_o}, 32'd0);
        step();
        reset = 1'b0;
        #1;
        chk("mul_rel.ready", {31'd0, ready_o}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk_out("mul_aborted", 1'b0, 5'h00, 1'b0, 1'b0);
        end
`else
        req(7'b0000001, 3'b000, 3'b000);
        step();
        valid_i = 1'b0;
        chk_out("mext_off", 1'b1, 5'h00, 1'b1, 1'b0);
        chk("mext_off.ready", {31'd0, ready_o}, 32'd1);
        step();
        chk_out("mext_off_hold", 1'b0, 5'h00, 1'b1, 1'b0);
        req(7'b0000001, 3'b000, 3'b100);
        step();
        valid_i = 1'b0;
        chk_out("mext_off_div", 1'b1, 5'h00, 1'b1, 1'b0);
        step();
        chk("mext_off_div.stall", {31'd0, stall_o}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_control_seq.md
# alu_control_seq

Registered, parametrised ALU control unit with optional multi-cycle M-extension sequencing. Sits between the main control unit / instruction register and the ALU: decodes {funct7, ALU_Op, funct3} into an ALU operation code, registers it with a valid/ready handshake, and holds the pipeline with a stall while a multiply/divide runs for a configurable number of cycles.

## Interface
Parameters:
- OP_W, 5, width of ALU_Operation_o; ≥4 without M-extension, ≥5 with it; codes zero-extended to OP_W
- MUL_CYCLES, 4, latency of MUL/MULH/MULHSU/MULHU in cycles (≥1)
- DIV_CYCLES, 32, latency of DIV/DIVU/REM/REMU in cycles (≥1)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- valid_i  in  1  decode request present
- ready_o  out  1  unit can accept a request
- funct7_i  in  7  instruction bits [31:25]
- ALU_Op_i  in  3  ALU operation class from control unit
- funct3_i  in  3  instruction bits [14:12]
- valid_o  out  1  one-cycle pulse: ALU_Operation_o result slot complete
- ALU_Operation_o  out  OP_W  registered ALU operation code
- stall_o  out  1  multi-cycle operation in progress
- illegal_o  out  1  registered with ALU_Operation_o: request matched no encoding

## Operation
- ALU_Op classes: 000 R, 001 I (ALU/load/JALR), 010 LUI, 011 store, 100 branch, 101 JAL; 110/111 illegal.
- Codes: ADD/ADDI/JALR/LW(I,f3=010) 0000; SUB (R,f7=0100000,f3=000) 0001; OR/ORI 0010; SLL/SLLI 0011; SRL/SRLI (f7=0000000) 0100; LUI 0101 (f3 ignored); AND/ANDI 0110; XOR/XORI 0111; BEQ 1000, BNE 1001, BLT 1010, BGE 1011 (other branch f3 illegal); JAL 1100 (f3 ignored); SW (store,f3=010) 1101; SRA/SRAI (f7=0100000,f3=101) 1110.
- I-type: funct7 ignored except f3=001 (requires f7=0000000) and f3=101 (selects SRL/SRA). R-type: funct7 must match exactly.
- Illegal request: ALU_Operation_o=0, illegal_o=1, valid_o pulses normally (single-cycle).
- FSM states IDLE, MULTI. ready_o = (state==IDLE) & ~reset.
- IDLE, valid_i & ready_o: register code and illegal_o; single-cycle op → valid_o=1 next cycle, stay IDLE; multi-cycle op with N>1 → counter=N-1, enter MULTI, valid_o=0.
- MULTI: stall_o=1, ready_o=0, valid_i ignored, ALU_Operation_o held; counter decrements each cycle; when counter==0 → next edge valid_o=1, return IDLE.
- ALU_Operation_o and illegal_o change only on accept; hold otherwise.

## Timing
- Reset values: ALU_Operation_o=0, illegal_o=0, valid_o=0, stall_o=0, state IDLE, counter 0; ready_o=0 during reset, 1 the cycle after.
- Single-cycle latency: accept at edge k → valid_o high for cycle after edge k.
- Multi-cycle latency N: accept at edge k → stall_o high cycles k..k+N-1, valid_o high after edge k+N with stall_o low; ready_o high in that same cycle, so back-to-back accept allowed (valid_o pulses each cycle for consecutive single-cycle ops).
- N=1 behaves exactly as single-cycle (MULTI never entered).
- Reset in MULTI: abort immediately, no valid_o pulse, outputs to reset values.
- Counter width $clog2(max(MUL_CYCLES,DIV_CYCLES)); no wrap possible.

## Configuration
- ALU_CTRL_MEXT_EN defined: R-type f7=0000001 decodes MUL..REMU as 16+funct3 (10000..10111); f3 0–3 use MUL_CYCLES, 4–7 DIV_CYCLES; MULTI state and counter present.
- Undefined: f7=0000001 is illegal (code 0, illegal_o=1, single-cycle); stall_o tied 0, FSM never leaves IDLE; OP_W=4 permitted.

## Test plan
- Reset, then R f7=0100000 f3=000 valid_i=1 → next cycle valid_o=1, ALU_Operation_o=0001, illegal_o=0.
- Consecutive I ADDI, I f7=0100000 f3=101, branch f3=101, JAL → valid_o high 4 cycles, codes 0000, 1110, 1011, 1100.
- ALU_Op=100 f3=010 → ALU_Operation_o=0, illegal_o=1, valid_o pulse.
- MEXT_EN, DIV_CYCLES=32: R f7=0000001 f3=100 → stall_o 32 cycles, ready_o=0, code 10100, valid_o 32 cycles after accept; new valid_i during stall ignored.
- MEXT_EN: MUL accepted, reset asserted 2 cycles later → no valid_o, all outputs 0, ready_o=1 cycle after release.
- Without macro: R f7=0000001 f3=000 → illegal_o=1, stall_o never asserts.
